// File: rtl/audio_feed_led_pkg.sv
// Shared types and constants for the audio_feed LED arbiter and its helper blocks.
package audio_feed_led_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  localparam int LED_W = 10;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Index width for n requesters, never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_feed_led_arbiter_if.sv
// Avalon-MM write-only link from the LED arbiter to the LED PIO s1 slave.
interface audio_feed_led_arbiter_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  modport master (output address, chipselect, write_n, writedata);
  modport slave  (input  address, chipselect, write_n, writedata);

endinterface

// File: rtl/audio_feed_rr_picker.sv
// Combinational round-robin picker: first set req bit after `last`, wrapping at N_REQ-1.
module audio_feed_rr_picker
  import audio_feed_led_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  int               start;
  int               idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    // An out-of-range last index (non power-of-two N_REQ) behaves as N_REQ-1.
    start  = (int'(last) >= N_REQ) ? N_REQ - 1 : int'(last);
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (start + k) % N_REQ;
      sel = IDX_W'(idx);
      if (!valid && req[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/audio_feed_led_arbiter.sv
// Round-robin sharer of the LED PIO register; each granted pattern is held for
// HOLD_CYCLES before another requester may take the LEDs.
module audio_feed_led_arbiter
  import audio_feed_led_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = LED_W,
  parameter int HOLD_CYCLES = 5_000_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]            ack,
  output logic [owner_w(N_REQ)-1:0]   owner,
  output logic                        busy,
  audio_feed_led_arbiter_if.master    avm
);

  localparam int IDX_W = owner_w(N_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_t            state, state_n;
  logic [IDX_W-1:0]  owner_n;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] pattern_n;

  audio_feed_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req),
    .last   (owner),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // The low bits of writedata double as the pattern latch.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    cnt_n     = cnt;
    pattern_n = avm.writedata[DATA_W-1:0];
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n   = WRITE;
          owner_n   = pick_idx;
          pattern_n = req_data[int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      WRITE: begin
        if (HOLD_CYCLES == 0) begin
          state_n = IDLE;
        end else begin
          state_n = HOLD;
          cnt_n   = CNT_W'(HOLD_CYCLES);
        end
      end
      HOLD: begin
        // An owner refresh wins over expiry; non-owners wait for IDLE.
        if (req[owner]) begin
          state_n   = WRITE;
          pattern_n = req_data[int'(owner)*DATA_W +: DATA_W];
        end else if (cnt <= CNT_W'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the strobe lines up with WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      owner          <= IDX_W'(N_REQ - 1);
      cnt            <= '0;
      ack            <= '0;
      busy           <= 1'b0;
      avm.address    <= PIO_DATA_ADDR;
      avm.chipselect <= 1'b0;
      avm.write_n    <= 1'b1;
      avm.writedata  <= '0;
    end else begin
      state          <= state_n;
      owner          <= owner_n;
      cnt            <= cnt_n;
      ack            <= (state_n == WRITE) ? (N_REQ'(1) << owner_n) : '0;
      busy           <= (state_n != IDLE);
      avm.address    <= PIO_DATA_ADDR;
      avm.chipselect <= (state_n == WRITE);
      avm.write_n    <= (state_n != WRITE);
      if (state_n == WRITE) avm.writedata <= 32'(pattern_n);
    end
  end

endmodule

// File: tb/tb_audio_feed_led_arbiter.sv
// Bench for audio_feed_led_arbiter: one instance with HOLD_CYCLES=4, one with 0.
module tb_audio_feed_led_arbiter;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ack;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  req;
    logic [9:0]  d0;
    logic [9:0]  d1;
    logic [1:0]  ack;
    logic [31:0] wd;
    logic        owner;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_h, req_z, ack_h, ack_z;
  logic [19:0] data_h, data_z;
  logic        owner_h, owner_z, busy_h, busy_z;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q[2][$];
  logic [31:0] last[2];
  vec_t        vecs[6];

  audio_feed_led_arbiter_if bus_h ();
  audio_feed_led_arbiter_if bus_z ();

  audio_feed_led_arbiter #(.N_REQ(2), .DATA_W(10), .HOLD_CYCLES(4)) dut_h (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req_h),
    .req_data (data_h),
    .ack      (ack_h),
    .owner    (owner_h),
    .busy     (busy_h),
    .avm      (bus_h)
  );

  audio_feed_led_arbiter #(.N_REQ(2), .DATA_W(10), .HOLD_CYCLES(0)) dut_z (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req_z),
    .req_data (data_z),
    .ack      (ack_z),
    .owner    (owner_z),
    .busy     (busy_z),
    .avm      (bus_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int d, input logic [31:0] data, input logic [1:0] a, input int c);
    exp_t e;
    e.data = data;
    e.ack  = a;
    e.cyc  = c;
    q[d].push_back(e);
  endtask

  task automatic mon(input int d, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic [1:0] a);
    exp_t e;
    if (cs) begin
      check($sformatf("strobe%0d", d), 32'(wn), 32'd0);
      check($sformatf("upper_bits%0d", d), 32'(wd[31:10]), 32'd0);
      checks++;
      if (q[d].size() == 0) begin
        errors++;
        $display("FAIL unexpected_write%0d got data %h ack %b, expected no write (cycle %0d)",
                 d, wd, a, cyc);
      end else begin
        e = q[d].pop_front();
        check($sformatf("data%0d", d), wd, e.data);
        check($sformatf("ack%0d", d), 32'(a), 32'(e.ack));
        check($sformatf("write_cycle%0d", d), 32'(cyc), 32'(e.cyc));
      end
      last[d] = wd;
    end else begin
      check($sformatf("idle_bus%0d", d), 32'({wn, a}), 32'h4);
      check($sformatf("hold_wdata%0d", d), wd, last[d]);
    end
  endtask

  task automatic wait_ack(input int i);
    int n = 0;
    while (ack_h[i] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("ack_wait%0d", i), 32'(ack_h[i]), 32'd1);
  endtask

  // Scoreboard consumer: sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (!reset_n) begin
      last[0] = '0;
      last[1] = '0;
    end else begin
      mon(0, bus_h.chipselect, bus_h.write_n, bus_h.writedata, ack_h);
      mon(1, bus_z.chipselect, bus_z.write_n, bus_z.writedata, ack_z);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0] = '{req: 2'b01, d0: 10'h2A5, d1: 10'h000, ack: 2'b01, wd: 32'h0000_02A5, owner: 1'b0};
    vecs[1] = '{req: 2'b10, d0: 10'h000, d1: 10'h3FF, ack: 2'b10, wd: 32'h0000_03FF, owner: 1'b1};
    vecs[2] = '{req: 2'b10, d0: 10'h000, d1: 10'h155, ack: 2'b10, wd: 32'h0000_0155, owner: 1'b1};
    vecs[3] = '{req: 2'b01, d0: 10'h000, d1: 10'h3FF, ack: 2'b01, wd: 32'h0000_0000, owner: 1'b0};
    vecs[4] = '{req: 2'b01, d0: 10'h3FF, d1: 10'h000, ack: 2'b01, wd: 32'h0000_03FF, owner: 1'b0};
    vecs[5] = '{req: 2'b10, d0: 10'h3FF, d1: 10'h2AA, ack: 2'b10, wd: 32'h0000_02AA, owner: 1'b1};

    req_h = '0; req_z = '0; data_h = '0; data_z = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    check("rst_cs", 32'(bus_h.chipselect), 32'd0);
    check("rst_write_n", 32'(bus_h.write_n), 32'd1);
    check("rst_address", 32'(bus_h.address), 32'd0);
    check("rst_wdata", bus_h.writedata, 32'd0);
    check("rst_ack", 32'(ack_h), 32'd0);
    check("rst_owner", 32'(owner_h), 32'd1);
    check("rst_busy", 32'(busy_h), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      data_h = {vecs[i].d1, vecs[i].d0};
      req_h  = vecs[i].req;
      push(0, vecs[i].wd, vecs[i].ack, cyc + 1);
      tick();
      check($sformatf("vec%0d_owner", i), 32'(owner_h), 32'(vecs[i].owner));
      check($sformatf("vec%0d_busy", i), 32'(busy_h), 32'd1);
      req_h = '0;
      repeat (8) tick();
      check($sformatf("vec%0d_idle", i), 32'(busy_h), 32'd0);
    end

    // Reset asserted in the middle of a write.
    req_h = 2'b01; data_h = {10'h000, 10'h0AB};
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_cs", 32'(bus_h.chipselect), 32'd0);
    check("midrst_write_n", 32'(bus_h.write_n), 32'd1);
    check("midrst_ack", 32'(ack_h), 32'd0);
    check("midrst_owner", 32'(owner_h), 32'd1);
    check("midrst_wdata", bus_h.writedata, 32'd0);
    req_h = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    req_h = 2'b01; data_h = {10'h000, 10'h2A5};
    push(0, 32'h0000_02A5, 2'b01, cyc + 1);
    tick();
    req_h = '0;
    repeat (8) tick();

    // Hold: requester 1 waits HOLD_CYCLES+2 after requester 0's write.
    req_h = 2'b01; data_h = {10'h000, 10'h011};
    w = cyc + 1;
    push(0, 32'h0000_0011, 2'b01, w);
    tick();
    req_h = 2'b10; data_h = {10'h099, 10'h011};
    push(0, 32'h0000_0099, 2'b10, w + 6);
    wait_ack(1);
    req_h = '0;
    repeat (8) tick();

    // Owner refresh during HOLD while requester 1 waits.
    req_h = 2'b01; data_h = {10'h000, 10'h005};
    w = cyc + 1;
    push(0, 32'h0000_0005, 2'b01, w);
    tick();
    req_h = 2'b10; data_h = {10'h0C3, 10'h005};
    tick();
    req_h = 2'b11; data_h = {10'h0C3, 10'h3FF};
    push(0, 32'h0000_03FF, 2'b01, w + 2);
    tick();
    req_h = 2'b10;
    push(0, 32'h0000_00C3, 2'b10, w + 8);
    wait_ack(1);
    req_h = '0;
    repeat (8) tick();

    // Owner request lands in the same cycle the hold counter expires.
    req_h = 2'b01; data_h = {10'h000, 10'h001};
    w = cyc + 1;
    push(0, 32'h0000_0001, 2'b01, w);
    tick();
    req_h = 2'b10; data_h = {10'h0F0, 10'h001};
    repeat (4) tick();
    req_h = 2'b11; data_h = {10'h0F0, 10'h1E1};
    push(0, 32'h0000_01E1, 2'b01, w + 5);
    tick();
    req_h = 2'b10;
    push(0, 32'h0000_00F0, 2'b10, w + 11);
    wait_ack(1);
    req_h = '0;
    repeat (8) tick();

    // Round-robin with no hold: both requesters held high.
    req_z = 2'b11; data_z = {10'h0FF, 10'h100};
    w = cyc;
    push(1, 32'h0000_0100, 2'b01, w + 1);
    push(1, 32'h0000_00FF, 2'b10, w + 3);
    push(1, 32'h0000_0100, 2'b01, w + 5);
    push(1, 32'h0000_00FF, 2'b10, w + 7);
    repeat (7) tick();
    req_z = '0;
    repeat (4) tick();
    check("rr_owner_z", 32'(owner_z), 32'd1);
    check("rr_idle_z", 32'(busy_z), 32'd0);

    check("pending_h", 32'(q[0].size()), 32'd0);
    check("pending_z", 32'(q[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
